// File: rtl/mouse_ctrl_pkg.sv
// rtl/mouse_ctrl_pkg.sv - state encoding and field widths for the mouse move controller
package mouse_ctrl_pkg;

  localparam int BLOCK_X_W = 5;
  localparam int BLOCK_Y_W = 3;
  localparam int TIMER_W   = 27;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEL  = 2'd1;
  localparam logic [1:0] ST_REQ  = 2'd2;

endpackage

// File: rtl/click_edge_det.sv
// rtl/click_edge_det.sv - one-cycle pulse on each rising edge of a button level
// The first edge after reset only primes the history, so a button held through reset is not a press.
module click_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);

  logic level_d;
  logic armed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_d <= 1'b0;
      armed   <= 1'b0;
    end else begin
      level_d <= level;
      armed   <= 1'b1;
    end
  end

  assign pulse = level & ~level_d & armed;

endmodule

// File: rtl/mouse_move_ctrl.sv
// rtl/mouse_move_ctrl.sv - two-click source/destination move selection with held move request
// Optional selection auto-cancel timer enabled by defining MOUSE_SEL_TIMEOUT_EN.
module mouse_move_ctrl
  import mouse_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid,
  input  logic                 l_click,
  input  logic [BLOCK_X_W-1:0] block_x,
  input  logic [BLOCK_Y_W-1:0] block_y,
  input  logic                 my_turn,
  input  logic                 move_ack,
  output logic                 sel_active,
  output logic [BLOCK_X_W-1:0] src_x,
  output logic [BLOCK_Y_W-1:0] src_y,
  output logic [BLOCK_X_W-1:0] dst_x,
  output logic [BLOCK_Y_W-1:0] dst_y,
  output logic                 move_req,
  output logic                 sel_cancel
);

  logic [1:0] state;
  logic       click_ev;
  logic       same_block;
  logic       sel_expired;

  click_edge_det u_click_edge (
    .clk   (clk),
    .rst   (rst),
    .level (l_click),
    .pulse (click_ev)
  );

  assign same_block = (block_x == src_x) && (block_y == src_y);
  assign sel_active = (state != ST_IDLE);
  assign move_req   = (state == ST_REQ);

`ifdef MOUSE_SEL_TIMEOUT_EN
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic [TIMER_W-1:0] sel_timer;

  // Held at zero outside SEL, so every entry into SEL starts a fresh period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_timer <= '0;
    end else if (state != ST_SEL) begin
      sel_timer <= '0;
    end else if (!sel_expired) begin
      sel_timer <= sel_timer + 1'b1;
    end
  end

  assign sel_expired = (sel_timer == TIMER_LAST);
`else
  assign sel_expired = 1'b0;

  // TIMEOUT_CYCLES only feeds the optional timer; this build keeps SEL until a click or loss of turn.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      src_x      <= '0;
      src_y      <= '0;
      dst_x      <= '0;
      dst_y      <= '0;
      sel_cancel <= 1'b0;
    end else begin
      sel_cancel <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (click_ev && valid && my_turn) begin
            src_x <= block_x;
            src_y <= block_y;
            state <= ST_SEL;
          end
        end
        ST_SEL: begin
          // Losing the turn outranks any click; a click outranks the timer.
          if (!my_turn) begin
            state      <= ST_IDLE;
            sel_cancel <= 1'b1;
          end else if (click_ev) begin
            if (valid && !same_block) begin
              dst_x <= block_x;
              dst_y <= block_y;
              state <= ST_REQ;
            end else begin
              state      <= ST_IDLE;
              sel_cancel <= 1'b1;
            end
          end else if (sel_expired) begin
            state      <= ST_IDLE;
            sel_cancel <= 1'b1;
          end
        end
        ST_REQ: begin
          if (move_ack) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mouse_move_ctrl.sv
// tb/tb_mouse_move_ctrl.sv - scoreboard bench for mouse_move_ctrl with a behavioural reference model
module tb_mouse_move_ctrl;

  localparam int TO = 20;
`ifdef MOUSE_SEL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam int EV_SELECT = 0;
  localparam int EV_MOVE   = 1;
  localparam int EV_CANCEL = 2;
  localparam int EV_DONE   = 3;
  localparam int EV_DROP   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic       l_click = 1'b0;
  logic [4:0] block_x = '0;
  logic [2:0] block_y = '0;
  logic       my_turn = 1'b0;
  logic       move_ack = 1'b0;
  logic       sel_active;
  logic [4:0] src_x;
  logic [2:0] src_y;
  logic [4:0] dst_x;
  logic [2:0] dst_y;
  logic       move_req;
  logic       sel_cancel;

  mouse_move_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid      (valid),
    .l_click    (l_click),
    .block_x    (block_x),
    .block_y    (block_y),
    .my_turn    (my_turn),
    .move_ack   (move_ack),
    .sel_active (sel_active),
    .src_x      (src_x),
    .src_y      (src_y),
    .dst_x      (dst_x),
    .dst_y      (dst_y),
    .move_req   (move_req),
    .sel_cancel (sel_cancel)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         kind;
    int         cyc;
    logic [4:0] sx;
    logic [2:0] sy;
    logic [4:0] dx;
    logic [2:0] dy;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: phase 0 = nothing chosen, 1 = source chosen, 2 = move awaiting acceptance.
  int         m_phase;
  int         m_age;
  bit         m_prev;
  bit         m_armed;
  logic [4:0] m_sx, m_dx;
  logic [2:0] m_sy, m_dy;

  function automatic void model_reset();
    m_phase = 0;
    m_age   = 0;
    m_prev  = 1'b0;
    m_armed = 1'b0;
    m_sx = '0; m_sy = '0; m_dx = '0; m_dy = '0;
  endfunction

  function automatic void expect_ev(int kind);
    exp_t e;
    e.kind = kind;
    e.cyc  = cyc + 1;
    e.sx = m_sx; e.sy = m_sy; e.dx = m_dx; e.dy = m_dy;
    exp_q.push_back(e);
  endfunction

  function automatic void model_edge();
    bit press;
    press   = l_click && !m_prev && m_armed;
    m_prev  = l_click;
    m_armed = 1'b1;
    case (m_phase)
      0: begin
        if (press && valid && my_turn) begin
          m_sx = block_x; m_sy = block_y;
          m_phase = 1;
          m_age = 0;
          expect_ev(EV_SELECT);
        end
      end
      1: begin
        m_age++;
        if (!my_turn) begin
          m_phase = 0; expect_ev(EV_CANCEL);
        end else if (press && valid && ({block_x, block_y} != {m_sx, m_sy})) begin
          m_dx = block_x; m_dy = block_y;
          m_phase = 2;
          expect_ev(EV_MOVE);
        end else if (press) begin
          m_phase = 0; expect_ev(EV_CANCEL);
        end else if (TO_EN && m_age == TO) begin
          m_phase = 0; expect_ev(EV_CANCEL);
        end
      end
      default: begin
        if (move_ack) begin
          m_phase = 0; expect_ev(EV_DONE);
        end
      end
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic drive(input logic l, input logic v, input logic [4:0] x, input logic [2:0] y,
                       input logic t, input logic a);
    l_click = l; valid = v; block_x = x; block_y = y; my_turn = t; move_ack = a;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic click(input logic [4:0] x, input logic [2:0] y);
    drive(1'b1, 1'b1, x, y, 1'b1, 1'b0);
    drive(1'b0, 1'b1, x, y, 1'b1, 1'b0);
  endtask

  task automatic do_reset(input logic hold);
    @(negedge clk);
    #1;
    rst = 1'b1;
    l_click = hold;
    model_reset();
    #1;
    check("async_reset_outputs", {sel_active, move_req, sel_cancel, src_x, src_y, dst_x, dst_y}, '0);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: every output event must match the head of the expectation queue, cycle-exact.
  bit p_sa = 1'b0;
  bit p_mr = 1'b0;
  always @(negedge clk) begin
    int   kind;
    exp_t e;
    if (rst) begin
      p_sa = sel_active;
      p_mr = move_req;
    end else begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        tests++;
        fails++;
        $display("FAIL missing_event: kind %0d due cycle %0d, not observed by cycle %0d",
                 exp_q[0].kind, exp_q[0].cyc, cyc);
        void'(exp_q.pop_front());
      end
      kind = -1;
      if (sel_cancel)               kind = EV_CANCEL;
      else if (move_req && !p_mr)   kind = EV_MOVE;
      else if (!move_req && p_mr)   kind = EV_DONE;
      else if (sel_active && !p_sa) kind = EV_SELECT;
      else if (!sel_active && p_sa) kind = EV_DROP;
      if (kind >= 0) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_event: kind %0d at cycle %0d, none required", kind, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.kind != kind || e.cyc != cyc || {src_x, src_y, dst_x, dst_y} != {e.sx, e.sy, e.dx, e.dy}) begin
            fails++;
            $display("FAIL event: got kind %0d cyc %0d src (%0d,%0d) dst (%0d,%0d), required kind %0d cyc %0d src (%0d,%0d) dst (%0d,%0d)",
                     kind, cyc, src_x, src_y, dst_x, dst_y, e.kind, e.cyc, e.sx, e.sy, e.dx, e.dy);
          end
        end
      end
      p_sa = sel_active;
      p_mr = move_req;
    end
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {sel_active, move_req, sel_cancel, src_x, src_y, dst_x, dst_y}, '0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 3'd0, 1'b1, 1'b0);

    // Select (3,2), then move to (7,1)
    drive(1'b1, 1'b1, 5'd3, 3'd2, 1'b1, 1'b0);
    check("sel_after_first_click", sel_active, 1'b1);
    drive(1'b0, 1'b1, 5'd3, 3'd2, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 5'd7, 3'd1, 1'b1, 1'b0);
    check("move_after_second_click", {move_req, src_x, src_y, dst_x, dst_y}, {1'b1, 5'd3, 3'd2, 5'd7, 3'd1});

    // Handshake holds through clicks and turn changes
    for (int i = 0; i < 10; i++) begin
      drive(logic'(i % 2), 1'b1, 5'(i), 3'(i % 4), logic'(i % 3 != 0), 1'b0);
      check("req_hold", {sel_active, move_req, src_x, src_y, dst_x, dst_y},
            {1'b1, 1'b1, 5'd3, 3'd2, 5'd7, 3'd1});
    end
    drive(1'b0, 1'b1, 5'd7, 3'd1, 1'b1, 1'b1);
    check("ack_returns_idle", {sel_active, move_req}, 2'b00);
    check("ack_keeps_regs", {src_x, src_y, dst_x, dst_y}, {5'd3, 3'd2, 5'd7, 3'd1});

    // Same-block click cancels
    click(5'd3, 3'd2);
    drive(1'b1, 1'b1, 5'd3, 3'd2, 1'b1, 1'b0);
    check("same_block_cancel", {sel_cancel, sel_active, move_req}, 3'b100);
    drive(1'b0, 1'b1, 5'd3, 3'd2, 1'b1, 1'b0);
    check("cancel_one_cycle", sel_cancel, 1'b0);

    // Held button gives one selection only
    repeat (50) drive(1'b1, 1'b1, 5'd4, 3'd0, 1'b1, 1'b0);
    check("held_single_select", {sel_active, move_req, src_x, src_y}, {1'b1, 1'b0, 5'd4, 3'd0});
    drive(1'b0, 1'b1, 5'd4, 3'd0, 1'b0, 1'b0);
    check("turn_loss_cancel", {sel_cancel, sel_active}, 2'b10);
    drive(1'b1, 1'b0, 5'd5, 3'd1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 5'd5, 3'd1, 1'b1, 1'b0);
    check("invalid_click_idle", {sel_active, src_x, src_y}, {1'b0, 5'd4, 3'd0});

`ifdef MOUSE_SEL_TIMEOUT_EN
    click(5'd2, 3'd1);
    repeat (TO + 4) drive(1'b0, 1'b1, 5'd2, 3'd1, 1'b1, 1'b0);
    check("timeout_dropped", sel_active, 1'b0);
    drive(1'b1, 1'b1, 5'd2, 3'd1, 1'b1, 1'b0);
    repeat (TO - 1) drive(1'b0, 1'b1, 5'd2, 3'd1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 5'd6, 3'd1, 1'b1, 1'b0);
    check("click_beats_timeout", {move_req, dst_x, dst_y}, {1'b1, 5'd6, 3'd1});
    drive(1'b0, 1'b1, 5'd6, 3'd1, 1'b1, 1'b1);
`else
    click(5'd2, 3'd1);
    repeat (60) drive(1'b0, 1'b1, 5'd2, 3'd1, 1'b1, 1'b0);
    check("sel_persists", sel_active, 1'b1);
    drive(1'b0, 1'b1, 5'd2, 3'd1, 1'b0, 1'b0);
`endif

    // Reset mid-handshake with the button held across release
    click(5'd1, 3'd1);
    drive(1'b1, 1'b1, 5'd6, 3'd0, 1'b1, 1'b0);
    check("in_req_before_reset", move_req, 1'b1);
    do_reset(1'b1);
    repeat (4) drive(1'b1, 1'b1, 5'd2, 3'd1, 1'b1, 1'b0);
    check("held_through_reset_no_event", sel_active, 1'b0);
    drive(1'b0, 1'b1, 5'd2, 3'd1, 1'b1, 1'b0);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 699) begin
        do_reset(logic'($urandom_range(0, 1)));
      end
      drive(logic'($urandom_range(0, 9) < 4), logic'($urandom_range(0, 19) < 17),
            5'($urandom_range(0, 3)), 3'($urandom_range(0, 1)),
            logic'($urandom_range(0, 19) < 18), logic'($urandom_range(0, 3) == 0));
    end

    repeat (4) drive(1'b0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mouse_move_ctrl.md
MOUSE_MOVE_CTRL -- requirements
Module: mouse_move_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100_000_000, selection auto-cancel period in clk cycles (1 s at 100 MHz).
REQ-002 SHALL have port clk  in  1  system clock; all state on rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port valid  in  1  cursor lies over a legal block.
REQ-005 SHALL have port l_click  in  1  left button level, high while pressed.
REQ-006 SHALL have port block_x  in  5  cursor block column.
REQ-007 SHALL have port block_y  in  3  cursor block row.
REQ-008 SHALL have port my_turn  in  1  local player may act.
REQ-009 SHALL have port move_ack  in  1  game logic accepts the pending move.
REQ-010 SHALL have port sel_active  out  1  a source block is selected.
REQ-011 SHALL have port src_x / src_y  out  5 / 3  selected source block.
REQ-012 SHALL have port dst_x / dst_y  out  5 / 3  destination block of the pending move.
REQ-013 SHALL have port move_req  out  1  move request, held until acknowledged.
REQ-014 SHALL have port sel_cancel  out  1  one-cycle pulse when a selection is dropped without a move.

Function
REQ-015 SHALL derive click event = l_click & ~l_click_d (registered previous level); one event per press; a held button creates no further events.
REQ-016 SHALL implement states IDLE, SEL, REQ.
REQ-017 IDLE: click event with valid & my_turn SHALL latch block_x/y into src_x/y and enter SEL next cycle; any other click is ignored.
REQ-018 SEL: click event with valid and (block_x,block_y) differing from src SHALL latch dst_x/y, assert move_req and enter REQ next cycle.
REQ-019 SEL: click event on the same block as src, or with valid=0, SHALL return to IDLE and pulse sel_cancel.
REQ-020 SEL: my_turn=0 SHALL return to IDLE and pulse sel_cancel; this takes priority over a simultaneous click.
REQ-021 REQ: move_req, src_x/y and dst_x/y SHALL stay stable until move_ack=1 is sampled; on that edge the block returns to IDLE and move_req drops in the same edge.
REQ-022 REQ: click events and my_turn changes SHALL be ignored; the handshake is never aborted except by rst.
REQ-023 move_ack outside REQ SHALL be ignored.
REQ-024 sel_active SHALL be 1 in SEL and REQ, 0 in IDLE.
REQ-025 src/dst registers SHALL hold their last values in IDLE; only latch events change them.

Reset
REQ-026 rst SHALL force IDLE, move_req=0, sel_active=0, sel_cancel=0, src/dst=0, l_click_d=0 and the timeout counter to 0 immediately, including mid-handshake.
REQ-027 A button already held when rst deasserts SHALL NOT produce a click event (l_click_d reloads from l_click on the first post-reset edge before edges are detected).

Configuration
REQ-028 With MOUSE_SEL_TIMEOUT_EN defined, a 27-bit counter SHALL run in SEL, clear on entry to SEL, and on reaching TIMEOUT_CYCLES-1 return to IDLE and pulse sel_cancel; a click event in the same cycle wins over timeout.
REQ-029 Without MOUSE_SEL_TIMEOUT_EN, no counter SHALL exist and SEL persists indefinitely.

Structure
REQ-030 Package mouse_ctrl_pkg SHALL hold the state encoding (IDLE=0, SEL=1, REQ=2) and constants BLOCK_X_W=5, BLOCK_Y_W=3.
REQ-031 Rising-edge detection SHALL be the sub-module click_edge_det (clk, rst, level in, pulse out).

Verification
REQ-032 Click (3,2) valid, my_turn=1; click (7,1) -> sel_active at +1 cycle; move_req=1, src=(3,2), dst=(7,1) at +1 cycle after second click.
REQ-033 Hold move_ack=0 for 10 cycles while toggling my_turn and clicking -> outputs unchanged; move_ack=1 -> IDLE, move_req=0 on that edge.
REQ-034 Select (3,2), click (3,2) again -> IDLE, sel_cancel high exactly 1 cycle, move_req never asserted.
REQ-035 l_click held 50 cycles over (4,0) in IDLE -> exactly one selection; click with valid=0 in IDLE -> no change.
REQ-036 TIMEOUT_CYCLES=20 with MOUSE_SEL_TIMEOUT_EN: select, no clicks -> sel_cancel on cycle 20 after entry; click on cycle 19 -> move instead.
REQ-037 Assert rst while in REQ -> move_req, sel_active, src, dst = 0 asynchronously; held button at release gives no event.
